// File: rtl/fpga_cond_pkg.sv
// Shared types and defaults for the board button / reset conditioner.
package fpga_cond_pkg;
  typedef enum logic [1:0] {ASSERT, STRETCH, RUN} rst_state_e;

  localparam int PRESS_CNT_W     = 8;
  localparam int DB_CYCLES_DEF   = 120000;
  localparam int RST_STRETCH_DEF = 4096;
endpackage

// File: rtl/fpga_debounce_chan.sv
// One input channel: synchroniser, stability counter and one-cycle edge pulses.
// RESET_LEVEL is the idle pad level; level_o is always 1 = pressed.
module fpga_debounce_chan #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 120000,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int CNT_W = $clog2(DB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_p;
  logic [CNT_W-1:0]       db_cnt;
  logic                   synced;

  assign synced = sync_p[SYNC_STAGES-1] ^ RESET_LEVEL;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      sync_p    <= {SYNC_STAGES{RESET_LEVEL}};
      db_cnt    <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      // stage: pad -> synchroniser
      sync_p    <= {sync_p[SYNC_STAGES-2:0], raw_i};
      // stage: synchroniser -> accepted level and pulses
      press_o   <= 1'b0;
      release_o <= 1'b0;
      if (synced == level_o) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
        db_cnt    <= '0;
        level_o   <= synced;
        press_o   <= synced;
        release_o <= ~synced;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/fpga_btn_rst_conditioner.sv
// Debounced buttons, edge pulses and a stretched glitch-free SoC reset for pulpissimo.
// Optional per-button saturating press counters: define FPGA_BTN_PRESS_CNT_EN.
module fpga_btn_rst_conditioner
  import fpga_cond_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int RST_STRETCH = RST_STRETCH_DEF
) (
  input  logic                         ref_clk,
  input  logic                         rst_ni,
  input  logic [N_BTN-1:0]             btn_raw_i,
  input  logic                         rst_btn_raw_ni,
  output logic [N_BTN-1:0]             btn_o,
  output logic [N_BTN-1:0]             btn_press_o,
  output logic [N_BTN-1:0]             btn_release_o,
  output logic                         soc_rst_no,
  output logic [PRESS_CNT_W*N_BTN-1:0] press_cnt_o
);
  localparam int STR_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

  logic             rb;
  logic             rb_press_unused;
  logic             rb_release_unused;
  rst_state_e       state, state_nxt;
  logic [STR_W-1:0] str_cnt, str_cnt_nxt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    fpga_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .RESET_LEVEL (1'b0)
    ) u_chan (
      .clk       (ref_clk),
      .rst_ni    (rst_ni),
      .raw_i     (btn_raw_i[i]),
      .level_o   (btn_o[i]),
      .press_o   (btn_press_o[i]),
      .release_o (btn_release_o[i])
    );
  end

  // Active-low pad, so idle level 1; rb reads 1 while the button is held.
  fpga_debounce_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES),
    .RESET_LEVEL (1'b1)
  ) u_rst_chan (
    .clk       (ref_clk),
    .rst_ni    (rst_ni),
    .raw_i     (rst_btn_raw_ni),
    .level_o   (rb),
    .press_o   (rb_press_unused),
    .release_o (rb_release_unused)
  );

  always_comb begin
    state_nxt   = state;
    str_cnt_nxt = str_cnt;
    case (state)
      ASSERT: begin
        if (!rb) begin
          state_nxt   = STRETCH;
          str_cnt_nxt = STR_W'(RST_STRETCH - 1);
        end
      end
      STRETCH: begin
        if (rb) begin
          state_nxt = ASSERT;
        end else if (str_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          str_cnt_nxt = str_cnt - STR_W'(1);
        end
      end
      RUN: begin
        if (rb) state_nxt = ASSERT;
      end
      default: state_nxt = ASSERT;
    endcase
  end

  // stage: FSM -> registered reset output (decoded from next state so the pad sees a clean flop)
  always_ff @(posedge ref_clk) begin
    if (!rst_ni) begin
      state      <= ASSERT;
      str_cnt    <= '0;
      soc_rst_no <= 1'b0;
    end else begin
      state      <= state_nxt;
      str_cnt    <= str_cnt_nxt;
      soc_rst_no <= (state_nxt == RUN);
    end
  end

`ifdef FPGA_BTN_PRESS_CNT_EN
  function automatic logic [PRESS_CNT_W-1:0] sat_inc(input logic [PRESS_CNT_W-1:0] v);
    return (v == {PRESS_CNT_W{1'b1}}) ? v : v + PRESS_CNT_W'(1);
  endfunction

  logic [PRESS_CNT_W*N_BTN-1:0] press_cnt_q;

  // stage: press pulses -> counters
  always_ff @(posedge ref_clk) begin
    if (!rst_ni) begin
      press_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_press_o[i]) begin
          press_cnt_q[i*PRESS_CNT_W +: PRESS_CNT_W] <=
            sat_inc(press_cnt_q[i*PRESS_CNT_W +: PRESS_CNT_W]);
        end
      end
    end
  end

  assign press_cnt_o = press_cnt_q;
`else
  assign press_cnt_o = '0;
`endif
endmodule
